// File: rtl/dac_rst_pulse_pkg.sv
// Shared definitions for the DAC reset-pulse PIO.
//   - word addresses of the slave registers
//   - bit positions inside the STATUS register
//   - sequencer state encoding
package dac_rst_pulse_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_PULSE  = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_PLEN   = 3'd3;
    localparam logic [2:0] ADDR_CTRL   = 3'd4;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/dac_rst_pulse_timer.sv
// Loadable down-counter used to time the pulse and the post-pulse hold-off.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset (count clears to 0)
//   load          load count from load_val (has priority over en)
//   load_val      value loaded on load
//   en            decrement enable; the counter stops at 0 and never wraps
//   count         current count
//   expire        count == 1, i.e. the current cycle is the last one timed
module dac_rst_pulse_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign count  = cnt_q;
    assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/dac_rst_pulse_pio.sv
// Avalon-MM slave driving WIDTH DAC reset/control lines with a hardware-timed
// inversion pulse, post-pulse hold-off, busy/done/err status and done interrupt.
// Ports:
//   clk, reset_n  system clock, synchronous active-low reset
//   address       word address (0 DATA, 1 PULSE, 2 STATUS, 3 PULSE_LEN, 4 CTRL)
//   chipselect    slave select; write = chipselect & ~write_n
//   write_n       active-low write strobe
//   writedata     write data; bits above WIDTH / CNT_W are ignored
//   readdata      combinational read mux on address, zero-extended
//   out_port      registered lines: DATA ^ (mask while pulsing)
//   irq           level interrupt, STATUS.done & CTRL.irq_en
//
// state | meaning
// IDLE  | lines follow DATA, a PULSE write with nonzero mask is accepted
// PULSE | masked lines inverted, pulse timer counting PULSE_LEN cycles
// HOLD  | lines back at DATA, hold timer counting HOLDOFF_CYCLES cycles
module dac_rst_pulse_pio
    import dac_rst_pulse_pkg::*;
#(
    parameter int unsigned       WIDTH          = 1,
    parameter logic [WIDTH-1:0]  RESET_VALUE    = WIDTH'(1),
    parameter int unsigned       CNT_W          = 16,
    parameter int unsigned       DEF_PULSE_LEN  = 16,
    parameter int unsigned       HOLDOFF_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    state_e           state_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] out_q;
    logic [CNT_W-1:0] plen_q;
    logic             irq_en_q;
    logic             done_q;
    logic             err_q;

    logic             wr;
    logic [WIDTH-1:0] wd_bits;
    logic [CNT_W-1:0] wd_plen;
    logic             start;
    logic             busy;
    logic             busy_wr;
    logic             clr_done;
    logic             clr_err;
    logic             set_done;
    logic             pulse_exp;
    logic             hold_exp;
    logic             hold_load;
    logic [CNT_W-1:0] pulse_cnt;
    logic [7:0]       hold_cnt;
    logic             unused_bits;

    assign wr       = chipselect & ~write_n;
    assign wd_bits  = writedata[WIDTH-1:0];
    assign wd_plen  = writedata[CNT_W-1:0];
    assign busy     = (state_q != IDLE);

    // A PULSE write while not IDLE (including the cycle the FSM is leaving
    // PULSE/HOLD) is rejected and flagged.
    assign start    = wr && (address == ADDR_PULSE) && !busy && (wd_bits != '0);
    assign busy_wr  = wr && (address == ADDR_PULSE) && busy;
    assign clr_done = wr && (address == ADDR_STATUS) && writedata[STAT_DONE];
    assign clr_err  = wr && (address == ADDR_STATUS) && writedata[STAT_ERR];

    assign hold_load = (state_q == PULSE) && pulse_exp && (HOLDOFF_CYCLES != 0);
    assign set_done  = ((state_q == PULSE) && pulse_exp && (HOLDOFF_CYCLES == 0))
                     || ((state_q == HOLD) && hold_exp);

    dac_rst_pulse_timer #(.CNT_W(CNT_W)) u_pulse_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (start),
        .load_val (plen_q),
        .en       (state_q == PULSE),
        .count    (pulse_cnt),
        .expire   (pulse_exp)
    );

    dac_rst_pulse_timer #(.CNT_W(8)) u_hold_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (hold_load),
        .load_val (8'(HOLDOFF_CYCLES)),
        .en       (state_q == HOLD),
        .count    (hold_cnt),
        .expire   (hold_exp)
    );

    // Raw counts and the ignored upper writedata bits are not needed here.
    assign unused_bits = ^{pulse_cnt, hold_cnt, writedata};

    // Register file: DATA, PULSE_LEN, CTRL.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q   <= RESET_VALUE;
            plen_q   <= CNT_W'(DEF_PULSE_LEN);
            irq_en_q <= 1'b0;
        end else begin
            if (wr && (address == ADDR_DATA)) begin
                data_q <= wd_bits;
            end
            // A zero length would never expire, so it is promoted to 1.
            if (wr && (address == ADDR_PLEN)) begin
                plen_q <= (wd_plen == '0) ? CNT_W'(1) : wd_plen;
            end
            if (wr && (address == ADDR_CTRL)) begin
                irq_en_q <= writedata[0];
            end
        end
    end

    // Sequencer with registered line outputs and status flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            out_q   <= RESET_VALUE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            out_q  <= data_q ^ ((state_q == PULSE) ? mask_q : '0);
            // Set wins over a same-cycle W1C clear.
            done_q <= set_done | (done_q & ~clr_done);
            err_q  <= busy_wr  | (err_q  & ~clr_err);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= PULSE;
                        mask_q  <= wd_bits;
                    end
                end
                PULSE: begin
                    if (pulse_exp) begin
                        state_q <= (HOLDOFF_CYCLES == 0) ? IDLE : HOLD;
                    end
                end
                HOLD: begin
                    if (hold_exp) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = 32'(data_q);
            ADDR_STATUS: begin
                readdata[STAT_BUSY] = busy;
                readdata[STAT_DONE] = done_q;
                readdata[STAT_ERR]  = err_q;
            end
            ADDR_PLEN:   readdata = 32'(plen_q);
            ADDR_CTRL:   readdata[0] = irq_en_q;
            default:     readdata = '0;
        endcase
    end

    assign out_port = out_q;
    assign irq      = done_q & irq_en_q;

endmodule
